// File: rtl/spi_pkg.sv
// Shared framing constants and state encoding for the soft SPI register link.
package spi_pkg;

  localparam int unsigned MSG_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned DATA_WIDTH = MSG_WIDTH - ADDR_WIDTH - 1;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StHold,
    StGap
  } master_state_e;

endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter; o_tick is high during the last cycle of a loaded period.
module spi_half_period_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_period,
  output logic             o_tick
);

  logic [Width-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_period - Width'(1);
    end else if (r_count != '0) begin
      r_count <= r_count - Width'(1);
    end
  end

  assign o_tick = (r_count == '0);

endmodule

// File: rtl/soft_spi_master.sv
// SPI initiator sending [rw, addr, data] frames MSB first; MOSI changes on SCK fall,
// MISO is sampled on SCK rise.
module soft_spi_master
  import spi_pkg::*;
#(
  parameter  int unsigned MsgWidth  = MSG_WIDTH,
  parameter  int unsigned AddrWidth = ADDR_WIDTH,
  parameter  int unsigned ClkDiv    = 4,
  parameter  int unsigned CsGap     = 4,
  localparam int unsigned DataWidth = MsgWidth - AddrWidth - 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_rw,
  input  logic [AddrWidth-1:0] i_addr,
  input  logic [DataWidth-1:0] i_wdata,
  input  logic                 i_keep_cs,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DataWidth-1:0] o_rdata,
  output logic                 o_sck,
  output logic                 o_ncs,
  output logic                 o_mosi,
  input  logic                 i_miso
);

  localparam int unsigned CntWidth   = $clog2(MsgWidth) + 1;
  localparam int unsigned TimerMax   = (ClkDiv > CsGap) ? ClkDiv : CsGap;
  localparam int unsigned TimerWidth = $clog2(TimerMax + 1);

  master_state_e         r_state, w_state_next;
  logic [MsgWidth-1:0]   r_tx_shift, w_tx_shift_next;
  logic [MsgWidth-1:0]   r_rx_shift, w_rx_shift_next;
  logic [CntWidth-1:0]   r_bit_cnt, w_bit_cnt_next;
  logic [DataWidth-1:0]  r_rdata, w_rdata_next;
  logic                  r_keep_cs, w_keep_cs_next;
  logic                  r_done, w_done_next;
  logic                  r_busy, w_busy_next;
  logic                  r_sck, w_sck_next;
  logic                  r_ncs, w_ncs_next;
  logic                  r_mosi, w_mosi_next;
  logic                  r_miso_meta, r_miso_sync;

  logic                  w_tick;
  logic                  w_timer_load;
  logic [TimerWidth-1:0] w_timer_period;

  spi_half_period_timer #(
    .Width(TimerWidth)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_timer_load),
    .i_period(w_timer_period),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_bit_cnt   <= '0;
      r_rdata     <= '0;
      r_keep_cs   <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_sck       <= 1'b0;
      r_ncs       <= 1'b1;
      r_mosi      <= 1'b0;
      r_miso_meta <= 1'b0;
      r_miso_sync <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_tx_shift  <= w_tx_shift_next;
      r_rx_shift  <= w_rx_shift_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_rdata     <= w_rdata_next;
      r_keep_cs   <= w_keep_cs_next;
      r_done      <= w_done_next;
      r_busy      <= w_busy_next;
      r_sck       <= w_sck_next;
      r_ncs       <= w_ncs_next;
      r_mosi      <= w_mosi_next;
      r_miso_meta <= i_miso;
      r_miso_sync <= r_miso_meta;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_tx_shift_next = r_tx_shift;
    w_rx_shift_next = r_rx_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_rdata_next    = r_rdata;
    w_keep_cs_next  = r_keep_cs;
    w_done_next     = 1'b0;
    w_busy_next     = r_busy;
    w_sck_next      = r_sck;
    w_ncs_next      = r_ncs;
    w_mosi_next     = r_mosi;
    w_timer_load    = 1'b0;
    w_timer_period  = TimerWidth'(ClkDiv);

    unique case (r_state)
      StIdle: begin
        w_sck_next = 1'b0;
        // After a keep_cs frame busy lingers one cycle in idle; start is ignored then.
        if (r_busy) begin
          w_busy_next = 1'b0;
        end else if (i_start) begin
          w_tx_shift_next = {i_rw, i_addr, i_wdata};
          w_keep_cs_next  = i_keep_cs;
          w_ncs_next      = 1'b0;
          w_mosi_next     = i_rw;
          w_bit_cnt_next  = '0;
          w_busy_next     = 1'b1;
          w_timer_load    = 1'b1;
          w_state_next    = StSetup;
        end
      end
      StSetup, StLow: begin
        if (w_tick) begin
          w_sck_next      = 1'b1;
          w_rx_shift_next = {r_rx_shift[MsgWidth-2:0], r_miso_sync};
          w_bit_cnt_next  = r_bit_cnt + CntWidth'(1);
          w_timer_load    = 1'b1;
          w_state_next    = StHigh;
        end
      end
      StHigh: begin
        if (w_tick) begin
          w_sck_next   = 1'b0;
          w_timer_load = 1'b1;
          if (r_bit_cnt == CntWidth'(MsgWidth)) begin
            w_state_next = StHold;
          end else begin
            w_tx_shift_next = {r_tx_shift[MsgWidth-2:0], 1'b0};
            w_mosi_next     = r_tx_shift[MsgWidth-2];
            w_state_next    = StLow;
          end
        end
      end
      StHold: begin
        if (w_tick) begin
          w_rdata_next = r_rx_shift[DataWidth-1:0];
          w_done_next  = 1'b1;
          if (r_keep_cs) begin
            w_state_next = StIdle;
          end else begin
            w_ncs_next     = 1'b1;
            w_timer_load   = 1'b1;
            w_timer_period = TimerWidth'(CsGap);
            w_state_next   = StGap;
          end
        end
      end
      StGap: begin
        if (w_tick) begin
          w_busy_next  = 1'b0;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_rdata = r_rdata;
  assign o_sck   = r_sck;
  assign o_ncs   = r_ncs;
  assign o_mosi  = r_mosi;

endmodule

// File: doc/soft_spi_master.md
Name: soft_spi_master

Overview:
SPI initiator for the FPGA-side register link. It generates one frame per request in the format [R/W bit, addr, data], MSB first, matching the soft_spi_slave framing. It drives MOSI on SCK falling edges and samples MISO on SCK rising edges. It is used for FPGA-to-FPGA and bench loopback access to soft_spi_slave register banks, and runs on the same system clock as the slave.

Parameters:
msg_width, 32, total frame bits (rw + addr + data)
addr_width, 7, address field bits
data_width, msg_width-addr_width-1, data field bits (derived; not overridable)
clk_div, 4, SCK half-period in clk cycles; minimum 4 so the slave's 2-stage SCK sync plus registered SO settles before the next rising edge
cs_gap, 4, clk cycles ncs is held high after a released frame before the next frame may start

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  request pulse; accepted only when busy=0
rw  in  1  1=read, 0=write; sampled at accept
addr  in  addr_width  target address; sampled at accept
wdata  in  data_width  write payload; sampled at accept (still shifted on reads)
keep_cs  in  1  1 = leave ncs low after this frame; sampled at accept
busy  out  1  frame or gap in progress
done  out  1  one-cycle pulse when the frame completes; rdata is valid in the same cycle
rdata  out  data_width  data captured from MISO during the data field
sck  out  1  SPI clock, idle low
ncs  out  1  chip select, active low
mosi  out  1  serial data out
miso  in  1  serial data in (async; passed through a 2-flop synchronizer before sampling)

Behaviour:
- Reset (async assert, sync release): sck=0, ncs=1, mosi=0, busy=0, done=0, rdata=0, state IDLE, counters cleared.
- A single phase timer counts clk_div cycles and issues a tick on the last cycle. Every non-IDLE state transition below occurs on that tick.
- IDLE: busy=0, sck=0.
  - On start: latch tx_shift={rw,addr,wdata}, keep_cs_r=keep_cs; set ncs=0, mosi=tx_shift MSB, bit_cnt=0, busy=1; go to SETUP.
  - If ncs is already low from a previous keep_cs frame, it stays low.
- SETUP: on tick, sck=1, sample synchronized miso into rx_shift LSB, bit_cnt+1; go to HIGH.
- HIGH: on tick, sck=0.
  - If bit_cnt==msg_width, go to HOLD.
  - Otherwise shift tx_shift, drive mosi with the next bit, and go to LOW.
- LOW: on tick, sck=1, sample miso, bit_cnt+1; go to HIGH.
- HOLD (sck low; the slave uses this falling edge to clear for the next packet): on tick, rdata=rx_shift[data_width-1:0] and done=1 for one cycle.
  - If keep_cs_r=1, go to IDLE with ncs=0.
  - Otherwise set ncs=1 and go to GAP.
- GAP: ncs=1; after cs_gap cycles go to IDLE with busy=0.
- Frame timing: 32 rising edges, 31 mid-frame falling edges plus the HOLD falling edge. done is asserted 65*clk_div cycles after the accept cycle (260 at defaults). busy deasserts cs_gap cycles later, or in the cycle after done when keep_cs=1.
- The first 1+addr_width sampled bits are discarded; the slave drives 0 during that phase.
- start while busy=1 is ignored and not queued. start held high in IDLE is accepted once per idle entry.
- rdata holds its value until the next done. On write frames rdata is still updated with whatever MISO carried.
- bit_cnt width is $clog2(msg_width)+1, so msg_width itself is representable without wrap.
- Reset mid-frame immediately returns all outputs to reset values, including ncs=1, which aborts the slave transfer.

Decomposition:
- Package spi_pkg holds:
  - the shared framing constants MSG_WIDTH and ADDR_WIDTH, and the DATA_WIDTH derivation;
  - the RW_READ/RW_WRITE encodings;
  - the master state enum (IDLE, SETUP, HIGH, LOW, HOLD, GAP).
- One natural sub-module, spi_half_period_timer: a parameterised down-counter with a load input and a tick output, reused for both the clk_div phases and the cs_gap count.

Test Plan:
- Write loopback to soft_spi_slave: rw=0, addr=0x15, wdata=0xABCDEF -> slave addr=0x15, rw=0, data_out=0xABCDEF with data_ready; master done exactly 260 cycles after accept; ncs high for 4 cycles before busy drops.
- Read loopback: rw=1, addr=0x2A, slave data_in=0x5A5A5A -> slave rw=1, addr=0x2A; master rdata=0x5A5A5A at done.
- Chained frames: frame 1 with keep_cs=1 (addr 0x01, wdata 0x000001), then frame 2 with keep_cs=0 (addr 0x02, wdata 0x000002) -> ncs never rises between frames; slave reports both packets correctly; ncs rises only after frame 2.
- start pulsed at cycle 100 of an active frame -> ignored; exactly 32 sck rising edges counted; one done pulse.
- rst_n asserted at cycle 120 mid-frame -> same-cycle sck=0, ncs=1, busy=0; slave counters clear; next frame after release completes normally.
- clk_div=8, rw=1, data_in=0xFFFFFF -> done at 520 cycles, rdata=0xFFFFFF; also check the MOSI bit sequence equals {1,addr,wdata} MSB first.
